// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output-capture path.
package fir_pkg;

    localparam int unsigned FIR_OUT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2
    } capState_t;

    // Round half up by 'shift' bits at FIR_OUT_W+1 precision, then clamp to a signed outW range.
    // Result is returned sign-extended to FIR_OUT_W bits; callers keep the low outW bits.
    function automatic logic signed [FIR_OUT_W-1:0] sat_round(
        input logic signed [FIR_OUT_W-1:0] x,
        input int unsigned                 shift,
        input int unsigned                 outW
    );
        logic signed [FIR_OUT_W:0] s;
        logic signed [FIR_OUT_W:0] hi;
        logic signed [FIR_OUT_W:0] lo;
        s  = {x[FIR_OUT_W-1], x};
        s  = s + (FIR_OUT_W+1)'(32'd1 << (shift - 32'd1));
        s  = s >>> shift;
        hi = (FIR_OUT_W+1)'((32'd1 << (outW - 32'd1)) - 32'd1);
        lo = ~hi;
        if (s > hi) begin
            return FIR_OUT_W'(hi);
        end else if (s < lo) begin
            return FIR_OUT_W'(lo);
        end
        return FIR_OUT_W'(s);
    endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// First-word-fall-through FIFO with a registered head, level and valid.
module fir_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned OUT_W = 8
) (
    input  logic                       iClk_12MHz,
    input  logic                       iRsn,
    input  logic                       iPush,
    input  logic [OUT_W-1:0]           iPushData,
    input  logic                       iReady,
    output logic                       oValid,
    output logic [OUT_W-1:0]           oData,
    output logic [$clog2(DEPTH):0]     oLevel,
    output logic                       oDrop_c
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [OUT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rdPtr, wrPtr, rdNext;
    logic [LVL_W-1:0] level, levelNext;
    logic [OUT_W-1:0] headQ, headNext;
    logic             validQ;
    logic             full, pop, wrEn;

    // Handshake decode; a full FIFO still accepts a push when the head leaves in the same clock.
    always_comb begin
        full      = (level == LVL_W'(DEPTH));
        pop       = validQ & iReady;
        wrEn      = iPush & (~full | pop);
        oDrop_c   = iPush & full & ~pop;
        rdNext    = pop ? rdPtr + PTR_W'(1) : rdPtr;
        levelNext = level;
        case ({wrEn, pop})
            2'b10:   levelNext = level + LVL_W'(1);
            2'b01:   levelNext = level - LVL_W'(1);
            default: levelNext = level;
        endcase
        // Next head: bypass the incoming word when it lands in the head slot, hold when empty.
        headNext = headQ;
        if (levelNext != '0) begin
            if (wrEn && (wrPtr == rdNext)) begin
                headNext = iPushData;
            end else begin
                headNext = mem[rdNext];
            end
        end
    end

    // Storage array.
    always_ff @(posedge iClk_12MHz) begin
        if (wrEn) begin
            mem[wrPtr] <= iPushData;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge iClk_12MHz or negedge iRsn) begin
        if (!iRsn) begin
            rdPtr  <= '0;
            wrPtr  <= '0;
            level  <= '0;
            validQ <= 1'b0;
            headQ  <= '0;
        end else begin
            rdPtr  <= rdNext;
            if (wrEn) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            level  <= levelNext;
            validQ <= (levelNext != '0);
            headQ  <= headNext;
        end
    end

    assign oValid = validQ;
    assign oData  = headQ;
    assign oLevel = level;

endmodule

// File: rtl/fir_out_capture.sv
// Captures FIR output a fixed delay after each sample strobe, converts and buffers it.
module fir_out_capture
    import fir_pkg::*;
#(
    parameter int unsigned CAPTURE_DLY = 2,
    parameter int unsigned SHIFT       = 8,
    parameter int unsigned OUT_W       = 8,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                       iClk_12MHz,
    input  logic                       iRsn,
    input  logic                       iEnSample_600kHz,
    input  logic [FIR_OUT_W-1:0]       iFirIn,
    input  logic                       iReady,
    input  logic                       iClrFlags,
    output logic                       oValid,
    output logic [OUT_W-1:0]           oData,
    output logic [$clog2(DEPTH):0]     oLevel,
    output logic                       oOverflow,
    output logic                       oOverrun
);

    localparam int unsigned   CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CAPTURE_DLY - 1);

    capState_t        state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic             overrunSet_c;
    logic             push_c;
    logic [OUT_W-1:0] pushData_c;
    logic             drop_c;
    logic             overflowQ, overrunQ;

    // Next-state logic; the sample lands in the FIFO during CAPTURE, CAPTURE_DLY clocks after the strobe.
    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        overrunSet_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (iEnSample_600kHz) begin
                    cntNext   = CNT_LOAD;
                    stateNext = (CNT_LOAD == '0) ? ST_CAPTURE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (iEnSample_600kHz) begin
                    overrunSet_c = 1'b1;
                    cntNext      = CNT_LOAD;
                    stateNext    = (CNT_LOAD == '0) ? ST_CAPTURE : ST_WAIT;
                end else if (cnt <= CNT_W'(1)) begin
                    cntNext   = '0;
                    stateNext = ST_CAPTURE;
                end else begin
                    cntNext = cnt - CNT_W'(1);
                end
            end
            ST_CAPTURE: begin
                if (iEnSample_600kHz) begin
                    cntNext   = CNT_LOAD;
                    stateNext = (CNT_LOAD == '0) ? ST_CAPTURE : ST_WAIT;
                end else begin
                    stateNext = ST_IDLE;
                end
            end
            default: begin
                cntNext   = '0;
                stateNext = ST_IDLE;
            end
        endcase
    end

    // State and delay counter.
    always_ff @(posedge iClk_12MHz or negedge iRsn) begin
        if (!iRsn) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= stateNext;
            cnt   <= cntNext;
        end
    end

    // Conversion of the live FIR word into the FIFO write port.
    always_comb begin
        push_c     = (state == ST_CAPTURE);
        pushData_c = OUT_W'(sat_round(iFirIn, SHIFT, OUT_W));
    end

    // Sticky flags; a set in the same clock as a clear takes priority.
    always_ff @(posedge iClk_12MHz or negedge iRsn) begin
        if (!iRsn) begin
            overflowQ <= 1'b0;
            overrunQ  <= 1'b0;
        end else begin
            if (drop_c) begin
                overflowQ <= 1'b1;
            end else if (iClrFlags) begin
                overflowQ <= 1'b0;
            end
            if (overrunSet_c) begin
                overrunQ <= 1'b1;
            end else if (iClrFlags) begin
                overrunQ <= 1'b0;
            end
        end
    end

    fir_sync_fifo #(
        .DEPTH (DEPTH),
        .OUT_W (OUT_W)
    ) uFifo (
        .iClk_12MHz (iClk_12MHz),
        .iRsn       (iRsn),
        .iPush      (push_c),
        .iPushData  (pushData_c),
        .iReady     (iReady),
        .oValid     (oValid),
        .oData      (oData),
        .oLevel     (oLevel),
        .oDrop_c    (drop_c)
    );

    assign oOverflow = overflowQ;
    assign oOverrun  = overrunQ;

endmodule

// File: tb/tb_fir_out_capture.sv
// Scoreboard bench for fir_out_capture: stimulus queues expected words, a monitor checks them.
module tb_fir_out_capture;

    logic        iClk_12MHz = 1'b0;
    logic        iRsn;
    logic        iEnSample_600kHz;
    logic [15:0] iFirIn;
    logic        iReady;
    logic        iClrFlags;
    logic        oValid;
    logic [7:0]  oData;
    logic [2:0]  oLevel;
    logic        oOverflow;
    logic        oOverrun;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  expQ [$];
    logic [7:0]  monExp;

    fir_out_capture #(
        .CAPTURE_DLY (2),
        .SHIFT       (8),
        .OUT_W       (8),
        .DEPTH       (4)
    ) dut (
        .iClk_12MHz       (iClk_12MHz),
        .iRsn             (iRsn),
        .iEnSample_600kHz (iEnSample_600kHz),
        .iFirIn           (iFirIn),
        .iReady           (iReady),
        .iClrFlags        (iClrFlags),
        .oValid           (oValid),
        .oData            (oData),
        .oLevel           (oLevel),
        .oOverflow        (oOverflow),
        .oOverrun         (oOverrun)
    );

    always #5 iClk_12MHz = ~iClk_12MHz;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every accepted output word is compared with the oldest expected word.
    always @(negedge iClk_12MHz) begin
        if (iRsn && oValid && iReady) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got 0x%0h, expected no word", oData);
            end else begin
                monExp = expQ.pop_front();
                check("oData", int'(oData), int'(monExp));
            end
        end
    end

    task automatic tick();
        @(posedge iClk_12MHz);
        #1;
    endtask

    // One strobe with a steady FIR word, then idle for the rest of the gap.
    task automatic sample(input logic [15:0] v, input logic [7:0] exp, input bit expect_it, input int gap);
        iFirIn           = v;
        iEnSample_600kHz = 1'b1;
        if (expect_it) expQ.push_back(exp);
        tick();
        iEnSample_600kHz = 1'b0;
        repeat (gap - 1) tick();
    endtask

    initial begin
        iRsn             = 1'b0;
        iEnSample_600kHz = 1'b0;
        iFirIn           = '0;
        iReady           = 1'b0;
        iClrFlags        = 1'b0;
        repeat (3) tick();
        iRsn = 1'b1;
        tick();

        // T1: reset mid-WAIT with two words buffered
        sample(16'h0100, 8'h00, 1'b0, 6);
        sample(16'h0200, 8'h00, 1'b0, 6);
        check("t1_level_before_reset", int'(oLevel), 2);
        iFirIn           = 16'h0300;
        iEnSample_600kHz = 1'b1;
        tick();
        iEnSample_600kHz = 1'b0;
        iRsn             = 1'b0;
        #2;
        check("t1_rst_valid", int'(oValid), 0);
        check("t1_rst_data", int'(oData), 0);
        check("t1_rst_level", int'(oLevel), 0);
        check("t1_rst_overflow", int'(oOverflow), 0);
        check("t1_rst_overrun", int'(oOverrun), 0);
        repeat (2) tick();
        iRsn = 1'b1;
        tick();
        repeat (4) tick();
        check("t1_no_stale_capture", int'(oLevel), 0);
        iReady = 1'b1;
        sample(16'h0100, 8'h01, 1'b1, 20);

        // T2: rounding
        sample(16'h0100, 8'h01, 1'b1, 20);
        sample(16'h0080, 8'h01, 1'b1, 20);
        sample(16'h007F, 8'h00, 1'b1, 20);
        sample(16'hFF80, 8'h00, 1'b1, 20);

        // T3: saturation
        sample(16'h7FFF, 8'h7F, 1'b1, 20);
        sample(16'h8000, 8'h80, 1'b1, 20);
        sample(16'hC000, 8'hC0, 1'b1, 20);

        // T4: latency with a moving input
        iFirIn           = 16'h0100;
        iEnSample_600kHz = 1'b1;
        expQ.push_back(8'h03);
        tick();
        iEnSample_600kHz = 1'b0;
        iFirIn           = 16'h0200;
        tick();
        iFirIn = 16'h0300;
        @(negedge iClk_12MHz);
        check("t4_valid_at_n2", int'(oValid), 0);
        tick();
        iFirIn = 16'h0400;
        @(negedge iClk_12MHz);
        check("t4_valid_at_n3", int'(oValid), 1);
        repeat (10) tick();

        // T5: backpressure, overflow, then full with simultaneous pop and push
        iReady = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            sample(16'(i << 8), 8'(i), (i <= 4), 5);
        end
        check("t5_level_full", int'(oLevel), 4);
        check("t5_overflow_set", int'(oOverflow), 1);
        iFirIn           = 16'h0700;
        iEnSample_600kHz = 1'b1;
        expQ.push_back(8'h07);
        tick();
        iEnSample_600kHz = 1'b0;
        tick();
        iReady = 1'b1;
        tick();
        iReady = 1'b0;
        check("t5_level_after_swap", int'(oLevel), 4);
        check("t5_head_after_swap", int'(oData), 2);
        iReady = 1'b1;
        repeat (8) tick();
        check("t5_level_drained", int'(oLevel), 0);
        check("t5_valid_drained", int'(oValid), 0);
        check("t5_data_hold", int'(oData), 8'h07);
        iClrFlags = 1'b1;
        tick();
        iClrFlags = 1'b0;
        check("t5_overflow_clear", int'(oOverflow), 0);

        // T6: back-to-back strobes; clear coincides with the overrun event
        iFirIn           = 16'h0500;
        iEnSample_600kHz = 1'b1;
        expQ.push_back(8'h05);
        tick();
        iClrFlags = 1'b1;
        tick();
        iEnSample_600kHz = 1'b0;
        iClrFlags        = 1'b0;
        check("t6_overrun_set_wins", int'(oOverrun), 1);
        repeat (8) tick();
        check("t6_level_single_capture", int'(oLevel), 0);
        check("t6_overrun_sticky", int'(oOverrun), 1);
        iClrFlags = 1'b1;
        tick();
        iClrFlags = 1'b0;
        check("t6_overrun_clear", int'(oOverrun), 0);
        check("t6_overflow_clear", int'(oOverflow), 0);

        repeat (4) tick();
        check("scoreboard_empty", expQ.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Safety net against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
